// File: rtl/seg_defs.sv
// -----------------------------------------------------------------------------
// seg_defs
//   Shared definitions for the seven-segment display blocks.
//   - Segment bit positions within an active-low {dp,g,f,e,d,c,b,a} byte.
//   - 16-entry hex glyph table (active-low g..a), lowercase b and d.
//   - Scan FSM state encoding.
//   - Display word layout: the 32-bit hex value plus per-digit decimal points.
// -----------------------------------------------------------------------------
package seg_defs;

    // Bit positions inside an {dp,g,f,e,d,c,b,a} segment byte.
    localparam int SEG_A  = 0;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // All seven glyph segments off (active-low).
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g,f,e,d,c,b,a} glyphs. Listed from F down to 0 so that
    // HEX_GLYPH[n] selects the glyph for nibble n.
    localparam logic [15:0][6:0] HEX_GLYPH = {
        7'h0E,  // F
        7'h06,  // E
        7'h21,  // d
        7'h46,  // C
        7'h03,  // b
        7'h08,  // A
        7'h10,  // 9
        7'h00,  // 8
        7'h78,  // 7
        7'h02,  // 6
        7'h12,  // 5
        7'h19,  // 4
        7'h30,  // 3
        7'h24,  // 2
        7'h79,  // 1
        7'h40   // 0
    };

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } scan_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  dots;
    } disp_word_t;

endpackage

// File: rtl/seg_hex_decode.sv
// -----------------------------------------------------------------------------
// seg_hex_decode
//   Combinational nibble to seven-segment decoder (active-low g..a).
//   Ports:
//     nibble  in  4  hex value to display
//     blank   in  1  force all seven segments off
//     seg_n   out 7  {g,f,e,d,c,b,a}, active-low
// -----------------------------------------------------------------------------
module seg_hex_decode
    import seg_defs::*;
(
    input  logic [3:0] nibble,
    input  logic       blank,
    output logic [6:0] seg_n
);

    assign seg_n = blank ? SEG_BLANK : HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_hex_scan.sv
// -----------------------------------------------------------------------------
// seg_hex_scan
//   Multiplexed 8-digit hexadecimal driver for a common-anode seven-segment
//   display. A pending buffer captures each new word; it is copied into the
//   shown buffer only at a frame boundary (or when leaving OFF), so the display
//   never shows a mix of two words. Each digit slot starts with DEAD_CYCLES of
//   blanking to avoid ghosting, then drives the digit for the rest of the slot.
//
//   Parameters:
//     CLK_FREQ     clock frequency in MHz
//     SCAN_KHZ     digit slot rate in kHz (slot = CLK_FREQ*1000/SCAN_KHZ cycles)
//     DEAD_CYCLES  blanking cycles at the start of each slot
//     DIGITS       number of digits, fixed at 8
//
//   Ports:
//     clk    in  1   system clock
//     rst_n  in  1   asynchronous active-low reset
//     load   in  1   strobe: capture data/dots into the pending buffer
//     data   in  32  hex value, nibble i on digit i (digit 0 rightmost)
//     dots   in  8   decimal point per digit, active-high
//     en     in  1   display enable
//     seg_n  out 8   {dp,g,f,e,d,c,b,a}, active-low, registered
//     an_n   out 8   digit anodes, active-low one-hot, registered
//
//   Build option:
//     SEG_LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                                non-zero nibble have g..a forced off (digit 0
//                                always shows; dp unaffected).
// -----------------------------------------------------------------------------
module seg_hex_scan
    import seg_defs::*;
#(
    parameter int CLK_FREQ    = 100,
    parameter int SCAN_KHZ    = 1,
    parameter int DEAD_CYCLES = 16,
    parameter int DIGITS      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] data,
    input  logic [7:0]  dots,
    input  logic        en,
    output logic [7:0]  seg_n,
    output logic [7:0]  an_n
);

    localparam int PERIOD = CLK_FREQ * 1000 / SCAN_KHZ;
    localparam int CNT_W  = $clog2(PERIOD);
    localparam int IDX_W  = $clog2(DIGITS);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DIGITS - 1);

    scan_state_t       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              take_pend;

    disp_word_t        pend_q, shown_q;

    logic [3:0]        nibble;
    logic              digit_blank;
    logic [6:0]        glyph_n;
    logic [7:0]        seg_d, an_d;

    // -------------------------------------------------------------------------
    // Scan FSM: next state, counters and buffer-copy decision.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves
        // it unassigned, which would otherwise infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        take_pend = 1'b0;

        if (!en) begin
            state_d = ST_OFF;
            cnt_d   = '0;
            idx_d   = '0;
        end else begin
            unique case (state_q)
                ST_OFF: begin
                    state_d   = ST_BLANK;
                    cnt_d     = '0;
                    idx_d     = '0;
                    take_pend = 1'b1;
                end
                ST_BLANK: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == DEAD_LAST) begin
                        state_d = ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        idx_d   = idx_q + 1'b1;
                        state_d = ST_BLANK;
                        // Last digit finished: a new frame starts.
                        if (idx_q == IDX_LAST) begin
                            take_pend = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_OFF;
                    cnt_d   = '0;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Digit selection and decode from the shown buffer.
    // -------------------------------------------------------------------------
    assign nibble = shown_q.data[{idx_q, 2'b00} +: 4];

`ifdef SEG_LEADING_ZERO_BLANK_EN
    // Digit idx is a leading zero when it and every nibble above it are zero.
    assign digit_blank = (idx_q != '0) && ((shown_q.data >> {idx_q, 2'b00}) == 32'd0);
`else
    assign digit_blank = 1'b0;
`endif

    seg_hex_decode u_decode (
        .nibble (nibble),
        .blank  (digit_blank),
        .seg_n  (glyph_n)
    );

    always_comb begin
        an_d  = 8'hFF;
        seg_d = 8'hFF;
        if (state_q == ST_DRIVE) begin
            an_d                = ~(8'd1 << idx_q);
            seg_d[SEG_G:SEG_A]  = glyph_n;
            seg_d[SEG_DP]       = ~shown_q.dots[idx_q];
        end
    end

    // -------------------------------------------------------------------------
    // State, buffers and registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_OFF;
            cnt_q   <= '0;
            idx_q   <= '0;
            // NOTE: the two display buffers are only 80 flops, so they are
            // reset to show a clean 0 rather than power-up garbage.
            pend_q  <= '0;
            shown_q <= '0;
            an_n    <= 8'hFF;
            seg_n   <= 8'hFF;
        end else begin
            // NOTE: non-blocking assignments here make pend_q and shown_q
            // update together: a load coinciding with a frame start leaves
            // shown_q with the previous pend_q value.
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            if (load) begin
                pend_q <= {data, dots};
            end
            if (take_pend) begin
                shown_q <= pend_q;
            end
            an_n    <= an_d;
            seg_n   <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg_hex_scan.sv
// -----------------------------------------------------------------------------
// tb_seg_hex_scan
//   Directed bench for seg_hex_scan with PERIOD=10, DEAD_CYCLES=2, so each
//   digit is driven for 8 cycles out of every 10 and a frame is 80 cycles.
//   Outputs are sampled on the falling clock edge; inputs are driven there too.
//   Honors SEG_LEADING_ZERO_BLANK_EN for the leading-zero expectations.
// -----------------------------------------------------------------------------
module tb_seg_hex_scan;

    localparam int CLK_FREQ    = 1;
    localparam int SCAN_KHZ    = 100;
    localparam int DEAD_CYCLES = 2;

`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [7:0] LZ_SEG = 8'hFF;
`else
    localparam logic [7:0] LZ_SEG = 8'hC0;
`endif

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        load  = 1'b0;
    logic [31:0] data  = '0;
    logic [7:0]  dots  = '0;
    logic        en    = 1'b1;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    seg_hex_scan #(
        .CLK_FREQ    (CLK_FREQ),
        .SCAN_KHZ    (SCAN_KHZ),
        .DEAD_CYCLES (DEAD_CYCLES),
        .DIGITS      (8)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .data  (data),
        .dots  (dots),
        .en    (en),
        .seg_n (seg_n),
        .an_n  (an_n)
    );

    // One-cycle load strobe, driven at a falling edge.
    task automatic drive_load(input logic [31:0] d, input logic [7:0] p);
        data = d;
        dots = p;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    // Advance to the first sample of the next slot of digit d (bounded).
    task automatic wait_slot_start(input int d);
        logic [7:0] tgt;
        int n;
        tgt = ~(8'd1 << d);
        n = 0;
        while (an_n === tgt && n < 200) begin
            @(negedge clk);
            n++;
        end
        while (an_n !== tgt && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (an_n !== tgt) begin
            checks++;
            fails++;
            $display("FAIL slot_timeout digit %0d: an_n=%h required %h", d, an_n, tgt);
        end
    endtask

    task automatic test_reset;
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (an_n !== 8'hFF) begin
            fails++;
            $display("FAIL reset_an: an_n=%h required FF", an_n);
        end
        checks++;
        if (seg_n !== 8'hFF) begin
            fails++;
            $display("FAIL reset_seg: seg_n=%h required FF", seg_n);
        end
        rst_n = 1'b1;
        // OFF->BLANK, two BLANK cycles: still dark for three samples.
        repeat (3) @(negedge clk);
        checks++;
        if (an_n !== 8'hFF) begin
            fails++;
            $display("FAIL reset_blank_an: an_n=%h required FF", an_n);
        end
        @(negedge clk);
        checks++;
        if (an_n !== 8'hFE) begin
            fails++;
            $display("FAIL reset_first_digit_an: an_n=%h required FE", an_n);
        end
        checks++;
        if (seg_n !== 8'hC0) begin
            fails++;
            $display("FAIL reset_first_digit_seg: seg_n=%h required C0", seg_n);
        end
    endtask

    task automatic test_full_frame_decode;
        logic [7:0] exp_seg [8];
        logic [7:0] tgt;
        int n;
        // Nibbles F,E,D,C,B,A,9,8 on digits 0..7; dp only on digit 0.
        exp_seg = '{8'h0E, 8'h86, 8'hA1, 8'hC6, 8'h83, 8'h88, 8'h90, 8'h80};
        drive_load(32'h89ABCDEF, 8'h01);
        for (int d = 0; d < 8; d++) begin
            tgt = ~(8'd1 << d);
            wait_slot_start(d);
            checks++;
            if (seg_n !== exp_seg[d]) begin
                fails++;
                $display("FAIL decode_digit%0d: seg_n=%h required %h", d, seg_n, exp_seg[d]);
            end
            n = 1;
            @(negedge clk);
            while (an_n === tgt && n < 20) begin
                n++;
                @(negedge clk);
            end
            checks++;
            if (n != 8) begin
                fails++;
                $display("FAIL drive_len_digit%0d: low for %0d cycles required 8", d, n);
            end
        end
    endtask

    task automatic test_tear_free;
        drive_load(32'h22222222, 8'h00);
        wait_slot_start(0);  // frame still showing the previous word
        for (int d = 0; d < 8; d++) begin
            wait_slot_start(d);
            checks++;
            if (seg_n !== 8'hA4) begin
                fails++;
                $display("FAIL tear_old_digit%0d: seg_n=%h required A4", d, seg_n);
            end
            if (d == 3) begin
                drive_load(32'h11111111, 8'h00);
            end
        end
        for (int d = 0; d < 8; d++) begin
            wait_slot_start(d);
            checks++;
            if (seg_n !== 8'hF9) begin
                fails++;
                $display("FAIL tear_new_digit%0d: seg_n=%h required F9", d, seg_n);
            end
        end
    endtask

    task automatic test_load_at_wrap;
        wait_slot_start(2);
        drive_load(32'h33333333, 8'h00);
        wait_slot_start(7);
        // Seventh sample of digit 7 falls in the cycle whose edge wraps idx.
        repeat (6) @(negedge clk);
        drive_load(32'h44444444, 8'h00);
        wait_slot_start(0);
        checks++;
        if (seg_n !== 8'hB0) begin
            fails++;
            $display("FAIL wrap_old_digit0: seg_n=%h required B0", seg_n);
        end
        wait_slot_start(7);
        checks++;
        if (seg_n !== 8'hB0) begin
            fails++;
            $display("FAIL wrap_old_digit7: seg_n=%h required B0", seg_n);
        end
        wait_slot_start(0);
        checks++;
        if (seg_n !== 8'h99) begin
            fails++;
            $display("FAIL wrap_new_digit0: seg_n=%h required 99", seg_n);
        end
    endtask

    task automatic test_disable;
        wait_slot_start(3);
        repeat (2) @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        checks++;
        if (an_n !== 8'hF7) begin
            fails++;
            $display("FAIL disable_first_edge: an_n=%h required F7", an_n);
        end
        @(negedge clk);
        checks++;
        if (an_n !== 8'hFF || seg_n !== 8'hFF) begin
            fails++;
            $display("FAIL disable_blank: an_n=%h seg_n=%h required FF FF", an_n, seg_n);
        end
        drive_load(32'h55555555, 8'h80);
        repeat (5) @(negedge clk);
        checks++;
        if (an_n !== 8'hFF) begin
            fails++;
            $display("FAIL off_stays_dark: an_n=%h required FF", an_n);
        end
        en = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (an_n !== 8'hFF) begin
            fails++;
            $display("FAIL reenable_blank: an_n=%h required FF", an_n);
        end
        @(negedge clk);
        checks++;
        if (an_n !== 8'hFE || seg_n !== 8'h92) begin
            fails++;
            $display("FAIL reenable_digit0: an_n=%h seg_n=%h required FE 92", an_n, seg_n);
        end
        wait_slot_start(7);
        checks++;
        if (seg_n !== 8'h12) begin
            fails++;
            $display("FAIL reenable_digit7_dp: seg_n=%h required 12", seg_n);
        end
    endtask

    task automatic test_leading_zero;
        logic [7:0] exp_seg [8];
        exp_seg = '{8'hC0, 8'hC0, 8'h88, LZ_SEG, LZ_SEG, LZ_SEG, LZ_SEG, LZ_SEG};
        drive_load(32'h00000A00, 8'h00);
        for (int d = 0; d < 8; d++) begin
            wait_slot_start(d);
            checks++;
            if (seg_n !== exp_seg[d]) begin
                fails++;
                $display("FAIL lead_zero_digit%0d: seg_n=%h required %h", d, seg_n, exp_seg[d]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame_decode();
        test_tear_free();
        test_load_at_wrap();
        test_disable();
        test_leading_zero();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
